vga_timing: RTL and testbench

- Raster timing generator for the VGA output path.
- Sits directly downstream of the clock-divider counter: consumes its pixel-rate enable and produces pixel coordinates, sync pulses and a display-active flag for the pixel/colour stage.
- Also emits frame and line start pulses, used to drive animation counters.
- Default timing is 640x480@60 (25.175 MHz pixel rate, approximated by the enable).

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_axis.sv | 41 ++++
 rtl/vga_timing.sv | 71 +++++++
 tb/tb_vga_timing.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default raster constants and shared helpers.
package vga_timing_pkg;
    localparam int H_VISIBLE_DEF        = 640;
    localparam int H_FRONT_DEF          = 16;
    localparam int H_SYNC_DEF           = 96;
    localparam int H_BACK_DEF           = 48;
    localparam int V_VISIBLE_DEF        = 480;
    localparam int V_FRONT_DEF          = 10;
    localparam int V_SYNC_DEF           = 2;
    localparam int V_BACK_DEF           = 33;
    localparam int SYNC_ACTIVE_HIGH_DEF = 0;
    localparam int COUNT_MSB_DEF        = 9;

    function automatic int axis_total(input int visible, input int front, input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

    // Pin level for a sync pulse given the polarity setting.
    function automatic logic sync_level(input int active_high, input logic asserted);
        return (active_high != 0) ? asserted : ~asserted;
    endfunction
endpackage

// File: rtl/vga_axis.sv
// vga_axis: modulo-N raster axis counter with carry, sync-window and visible-window decode.
module vga_axis
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = H_VISIBLE_DEF,
    parameter int FRONT   = H_FRONT_DEF,
    parameter int SYNC    = H_SYNC_DEF,
    parameter int BACK    = H_BACK_DEF,
    parameter int W       = COUNT_MSB_DEF + 1
) (
    input  logic         clk,
    input  logic         restart_n,
    input  logic         en,
    output logic [W-1:0] pos,
    output logic         carry,
    output logic         in_sync,
    output logic         in_visible,
    output logic         at_zero
);
    localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
    // Inclusive bounds keep every constant inside W bits even when TOTAL == 2**W.
    localparam logic [W-1:0] LAST_POS   = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_FIRST = W'(VISIBLE + FRONT);
    localparam logic [W-1:0] SYNC_LAST  = W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [W-1:0] VIS_LAST   = W'(VISIBLE - 1);

    logic at_last;

    assign at_last    = pos == LAST_POS;
    assign carry      = en && at_last;
    assign in_sync    = (pos >= SYNC_FIRST) && (pos <= SYNC_LAST);
    assign in_visible = pos <= VIS_LAST;
    assign at_zero    = pos == '0;

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n)
            pos <= '0;
        else if (en)
            pos <= at_last ? '0 : pos + 1'b1;
    end
endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator producing registered coordinates, syncs and start pulses.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE        = H_VISIBLE_DEF,
    parameter int H_FRONT          = H_FRONT_DEF,
    parameter int H_SYNC           = H_SYNC_DEF,
    parameter int H_BACK           = H_BACK_DEF,
    parameter int V_VISIBLE        = V_VISIBLE_DEF,
    parameter int V_FRONT          = V_FRONT_DEF,
    parameter int V_SYNC           = V_SYNC_DEF,
    parameter int V_BACK           = V_BACK_DEF,
    parameter int SYNC_ACTIVE_HIGH = SYNC_ACTIVE_HIGH_DEF,
    parameter int COUNT_MSB        = COUNT_MSB_DEF
) (
    input  logic               clk,
    input  logic               restart_n,
    input  logic               pixel_en,
    output logic [COUNT_MSB:0] hcount,
    output logic [COUNT_MSB:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               line_start,
    output logic               frame_start
);
    localparam int W = COUNT_MSB + 1;

    logic [COUNT_MSB:0] h, v;
    logic h_carry, h_sync, h_vis, h_zero;
    logic v_sync, v_vis, v_zero;
    logic frame_end_unused;

    vga_axis #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(W)
    ) u_h (
        .clk(clk), .restart_n(restart_n), .en(pixel_en),
        .pos(h), .carry(h_carry), .in_sync(h_sync), .in_visible(h_vis), .at_zero(h_zero)
    );

    vga_axis #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(W)
    ) u_v (
        .clk(clk), .restart_n(restart_n), .en(pixel_en && h_carry),
        .pos(v), .carry(frame_end_unused), .in_sync(v_sync), .in_visible(v_vis), .at_zero(v_zero)
    );

    // Outputs lag the counters by one enabled edge; pulses drop on any non-enabled edge.
    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= sync_level(SYNC_ACTIVE_HIGH, 1'b0);
            vsync       <= sync_level(SYNC_ACTIVE_HIGH, 1'b0);
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pixel_en) begin
            hcount      <= h;
            vcount      <= v;
            hsync       <= sync_level(SYNC_ACTIVE_HIGH, h_sync);
            vsync       <= sync_level(SYNC_ACTIVE_HIGH, v_sync);
            active      <= h_vis && v_vis;
            line_start  <= h_zero;
            frame_start <= h_zero && v_zero;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: three parameterisations checked against an arithmetic raster model plus vector table.
module tb_vga_timing;
    typedef struct {int hc; int vc; int hs; int vs; int act; int ls; int fs;} out_t;
    typedef struct {bit rst_n; bit en; out_t exp;} vec_t;

    logic clk = 1'b0, restart_n = 1'b0, pixel_en = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] d_hc, d_vc, p_hc, p_vc;
    logic [3:0] s_hc, s_vc;
    logic d_hs, d_vs, d_act, d_ls, d_fs;
    logic s_hs, s_vs, s_act, s_ls, s_fs;
    logic p_hs, p_vs, p_act, p_ls, p_fs;

    vga_timing u_def (
        .clk(clk), .restart_n(restart_n), .pixel_en(pixel_en), .hcount(d_hc), .vcount(d_vc),
        .hsync(d_hs), .vsync(d_vs), .active(d_act), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .COUNT_MSB(3)
    ) u_small (
        .clk(clk), .restart_n(restart_n), .pixel_en(pixel_en), .hcount(s_hc), .vcount(s_vc),
        .hsync(s_hs), .vsync(s_vs), .active(s_act), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing #(
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE_HIGH(1)
    ) u_hi (
        .clk(clk), .restart_n(restart_n), .pixel_en(pixel_en), .hcount(p_hc), .vcount(p_vc),
        .hsync(p_hs), .vsync(p_vs), .active(p_act), .line_start(p_ls), .frame_start(p_fs)
    );

    localparam int D_HT = 800, D_VT = 525, S_HT = 8, S_VT = 6, P_VT = 8;
    initial if (D_HT > 1024 || D_VT > 1024 || S_HT > 16 || S_VT > 16 || P_VT > 1024) begin
        $display("FAIL elab: raster totals exceed counter range");
        $fatal(1);
    end

    int total = 0, bad = 0;
    int n = 0;
    bit le = 1'b0;

    // Model state: number of enabled edges since reset and whether the last edge was enabled.
    always @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            n = 0;
            le = 1'b0;
        end else begin
            le = pixel_en;
            if (pixel_en) n++;
        end
    end

    function automatic out_t mk(int hc, int vc, int hs, int vs, int act, int ls, int fs);
        out_t o;
        o = '{hc, vc, hs, vs, act, ls, fs};
        return o;
    endfunction

    function automatic out_t model(int cnt, bit last_en, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb, bit pol);
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int p, h, v;
        out_t o;
        if (cnt == 0) return mk(0, 0, int'(!pol), int'(!pol), 0, 0, 0);
        p = (cnt - 1) % (ht * vt);
        h = p % ht;
        v = p / ht;
        o.hc  = h;
        o.vc  = v;
        o.hs  = int'((h >= hv + hf && h < hv + hf + hs) == pol);
        o.vs  = int'((v >= vv + vf && v < vv + vf + vs) == pol);
        o.act = int'(h < hv && v < vv);
        o.ls  = int'(last_en && h == 0);
        o.fs  = int'(last_en && h == 0 && v == 0);
        return o;
    endfunction

    task automatic check(string nm, int a, int e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic check_out(string tag, out_t a, out_t e);
        check({tag, ".hcount"}, a.hc, e.hc);
        check({tag, ".vcount"}, a.vc, e.vc);
        check({tag, ".hsync"}, a.hs, e.hs);
        check({tag, ".vsync"}, a.vs, e.vs);
        check({tag, ".active"}, a.act, e.act);
        check({tag, ".line_start"}, a.ls, e.ls);
        check({tag, ".frame_start"}, a.fs, e.fs);
    endtask

    task automatic check_all(string when);
        check_out({when, " def"},
                  mk(int'(d_hc), int'(d_vc), int'(d_hs), int'(d_vs), int'(d_act), int'(d_ls), int'(d_fs)),
                  model(n, le, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        check_out({when, " small"},
                  mk(int'(s_hc), int'(s_vc), int'(s_hs), int'(s_vs), int'(s_act), int'(s_ls), int'(s_fs)),
                  model(n, le, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0));
        check_out({when, " hi"},
                  mk(int'(p_hc), int'(p_vc), int'(p_hs), int'(p_vs), int'(p_act), int'(p_ls), int'(p_fs)),
                  model(n, le, 640, 16, 96, 48, 4, 1, 2, 1, 1'b1));
    endtask

    always @(negedge clk) check_all("mon");

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t tbl[12];
    int hs_lo, vs_hi, fs_n, k;

    initial begin
        // Small-raster vectors: hsync is active-low on h=5,6; visible h<4, v<3.
        tbl[0]  = '{1'b0, 1'b1, mk(0, 0, 1, 1, 0, 0, 0)};
        tbl[1]  = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 1, 1)};
        tbl[2]  = '{1'b1, 1'b1, mk(1, 0, 1, 1, 1, 0, 0)};
        tbl[3]  = '{1'b1, 1'b0, mk(1, 0, 1, 1, 1, 0, 0)};
        tbl[4]  = '{1'b1, 1'b1, mk(2, 0, 1, 1, 1, 0, 0)};
        tbl[5]  = '{1'b1, 1'b1, mk(3, 0, 1, 1, 1, 0, 0)};
        tbl[6]  = '{1'b1, 1'b1, mk(4, 0, 1, 1, 0, 0, 0)};
        tbl[7]  = '{1'b1, 1'b1, mk(5, 0, 0, 1, 0, 0, 0)};
        tbl[8]  = '{1'b1, 1'b1, mk(6, 0, 0, 1, 0, 0, 0)};
        tbl[9]  = '{1'b1, 1'b0, mk(6, 0, 0, 1, 0, 0, 0)};
        tbl[10] = '{1'b1, 1'b1, mk(7, 0, 1, 1, 0, 0, 0)};
        tbl[11] = '{1'b1, 1'b1, mk(0, 1, 1, 1, 1, 1, 0)};
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            #1 restart_n = tbl[i].rst_n;
            pixel_en = tbl[i].en;
            @(negedge clk);
            check_out($sformatf("vec%0d", i),
                      mk(int'(s_hc), int'(s_vc), int'(s_hs), int'(s_vs), int'(s_act), int'(s_ls), int'(s_fs)),
                      tbl[i].exp);
        end

        // Continuous run from reset: sync widths and frame pulse count.
        #1 restart_n = 1'b0;
        @(negedge clk);
        #1 restart_n = 1'b1;
        pixel_en = 1'b1;
        hs_lo = 0; vs_hi = 0; fs_n = 0;
        for (int i = 0; i < 6400; i++) begin
            @(negedge clk);
            if (i < 800 && !d_hs) hs_lo++;
            if (p_vs) vs_hi++;
            if (i < 96 && s_fs) fs_n++;
        end
        check("hsync_width", hs_lo, 96);
        check("vsync_hi_pixels", vs_hi, 1600);
        check("small_frame_pulses", fs_n, 2);

        for (int i = 0; i < 200; i++) begin
            #1 pixel_en = (i % 2 == 0);
            @(negedge clk);
        end

        repeat (3000) begin
            #1 pixel_en = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        // Asynchronous reset landing between clock edges mid-frame.
        #1 restart_n = 1'b0;
        @(negedge clk);
        #1 restart_n = 1'b1;
        pixel_en = 1'b1;
        k = 0;
        while (!(d_hc == 10'd300 && d_vc == 10'd3) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("reach_300_3", int'(d_hc == 10'd300 && d_vc == 10'd3), 1);
        #2 restart_n = 1'b0;
        #1 check_all("async");
        check("async_hcount", int'(d_hc), 0);
        check("async_hsync", int'(d_hs), 1);
        check("async_hi_vsync", int'(p_vs), 0);
        @(negedge clk);
        #1 restart_n = 1'b1;
        @(negedge clk);
        check("restart_hcount", int'(d_hc), 0);
        check("restart_vcount", int'(d_vc), 0);
        check("restart_frame_start", int'(d_fs), 1);
        check("restart_active", int'(d_act), 1);

        repeat (500) begin
            #1 pixel_en = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
